lsu_axi: RTL and testbench
==========================

LSU_AXI -- requirements
Module: lsu_axi

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of upstream request and AXI address channels.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; legal values 32 or 64.
REQ-003 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1); one clock, reset synchronous and active-high.
REQ-004 SHALL have upstream request ports:
- req_valid_i in 1; req_ready_o out 1
- wen_i in 1; ren_i in 1
- addr_i in ADDR_W; wdata_i in DATA_W
- size_i in 2: 0 byte, 1 half, 2 word, 3 dword
- is_signed_i in 1: sign-extend loads
REQ-005 SHALL have upstream response ports: resp_valid_o out 1; resp_ready_i in 1; rdata_o out DATA_W; err_o out 1.
REQ-006 SHALL have AXI4-Lite master ports:
- awvalid_o/awready_i, awaddr_o ADDR_W
- wvalid_o/wready_i, wdata_o DATA_W, wstrb_o DATA_W/8
- bvalid_i/bready_o, bresp_i 2
- arvalid_o/arready_i, araddr_o ADDR_W
- rvalid_i/rready_o, rdata_i DATA_W, rresp_i 2

Function
REQ-007 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP; all outputs registered or decoded from state only.
REQ-008 SHALL assert req_ready_o only in IDLE; request accepted on req_valid_i && req_ready_o; request fields captured that cycle.
REQ-009 SHALL define OFF = addr_i[log2(DATA_W/8)-1:0] and NB = 1<<size_i.
REQ-010 SHALL treat as error, with no bus transaction, going directly IDLE->RESP with err_o=1 and rdata_o=0:
- wen_i && ren_i
- OFF not a multiple of NB
- size_i=3 with DATA_W=32
REQ-011 SHALL treat wen_i=ren_i=0 as a no-op: IDLE->RESP, err_o=0, rdata_o=0.
REQ-012 SHALL on valid read go IDLE->RD_ADDR: arvalid_o=1, araddr_o = addr with OFF bits cleared; on arready_i -> RD_DATA.
REQ-013 SHALL assert rready_o in RD_DATA; on rvalid_i:
- capture rdata_i >> (8*OFF), truncated to NB bytes, sign- or zero-extended per is_signed_i
- err = rresp_i[1]
- -> RESP
REQ-014 SHALL on valid write go IDLE->WR with awvalid_o=wvalid_o=1, awaddr_o aligned as araddr_o, wdata_o = wdata_i << (8*OFF), wstrb_o = ((1<<NB)-1) << OFF.
REQ-015 SHALL in WR drop awvalid_o after the AW handshake and wvalid_o after the W handshake independently (either order, or same cycle), and move to WR_RESP the cycle after both have completed.
REQ-016 SHALL assert bready_o in WR_RESP; on bvalid_i: err = bresp_i[1], rdata_o=0, -> RESP.
REQ-017 SHALL in RESP hold resp_valid_o=1 with rdata_o/err_o stable until resp_ready_i, then -> IDLE.
REQ-018 SHALL never assert more than one outstanding AXI transaction; AXI valids, once asserted, SHALL hold with stable payload until their handshake.
REQ-019 SHALL give minimum read latency of 3 cycles from acceptance to resp_valid_o with zero-wait slave (accept c0, AR c1, R c2, resp c3); error/no-op latency 1 cycle.

Reset
REQ-020 SHALL on rst_i sampled high set state IDLE; all valid/ready outputs 0 except req_ready_o=1 the cycle after reset; rdata_o=0; err_o=0.
REQ-021 SHALL on reset mid-transaction abandon the transaction immediately; no response is delivered and the AXI slave is reset with the system.

Verification
REQ-022 Load byte, signed, DATA_W=32: addr 0x8000_0003, slave rdata 0x80FF_FF12 -> araddr 0x8000_0000, rdata_o 0xFFFF_FF80, err_o 0, resp at c3.
REQ-023 Store half: addr 0x8000_0002, wdata_i 0x0000_BEEF; AW ready 2 cycles before W -> wdata_o 0xBEEF_0000, wstrb_o 4'b1100, one bready handshake, err_o 0.
REQ-024 Misaligned: word at 0x8000_0001 -> no arvalid/awvalid, resp_valid_o next cycle, err_o 1.
REQ-025 Slave error: load with rresp_i=2'b10 -> err_o 1; resp_ready_i held low 3 cycles -> resp_valid_o and data stable throughout.
REQ-026 Reset in RD_DATA before rvalid_i -> next cycle arvalid_o/rready_o 0, req_ready_o 1, no resp_valid_o.
REQ-027 DATA_W=64, load unsigned half at OFF 6, rdata_i 0xABCD_0000_0000_0000 -> rdata_o 0x0000_0000_0000_ABCD.

Source files
------------

// File: rtl/lsu_axi_if.sv
// Upstream request/response port and AXI4-Lite master port of the load/store unit.
// Signal suffixes are from the LSU's point of view on both interfaces.
interface lsu_req_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              wen_i;
   logic              ren_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic [1:0]        size_i;
   logic              is_signed_i;
   logic              resp_valid_o;
   logic              resp_ready_i;
   logic [DATA_W-1:0] rdata_o;
   logic              err_o;

   modport master (
      output req_valid_i, wen_i, ren_i, addr_i, wdata_i, size_i, is_signed_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, rdata_o, err_o
   );
   modport slave (
      input  req_valid_i, wen_i, ren_i, addr_i, wdata_i, size_i, is_signed_i, resp_ready_i,
      output req_ready_o, resp_valid_o, rdata_o, err_o
   );
endinterface

interface lsu_axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                awvalid_o;
   logic                awready_i;
   logic [ADDR_W-1:0]   awaddr_o;
   logic                wvalid_o;
   logic                wready_i;
   logic [DATA_W-1:0]   wdata_o;
   logic [DATA_W/8-1:0] wstrb_o;
   logic                bvalid_i;
   logic                bready_o;
   logic [1:0]          bresp_i;
   logic                arvalid_o;
   logic                arready_i;
   logic [ADDR_W-1:0]   araddr_o;
   logic                rvalid_i;
   logic                rready_o;
   logic [DATA_W-1:0]   rdata_i;
   logic [1:0]          rresp_i;

   modport master (
      output awvalid_o, awaddr_o, wvalid_o, wdata_o, wstrb_o, bready_o, arvalid_o, araddr_o, rready_o,
      input  awready_i, wready_i, bvalid_i, bresp_i, arready_i, rvalid_i, rdata_i, rresp_i
   );
   modport slave (
      input  awvalid_o, awaddr_o, wvalid_o, wdata_o, wstrb_o, bready_o, arvalid_o, araddr_o, rready_o,
      output awready_i, wready_i, bvalid_i, bresp_i, arready_i, rvalid_i, rdata_i, rresp_i
   );
endinterface

// File: rtl/lsu_axi.sv
// Single-outstanding load/store unit bridging aligned byte/half/word/dword
// requests onto an AXI4-Lite master; every output is a register.
module lsu_axi #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic      clk_i,
   input  logic      rst_i,
   lsu_req_if.slave  up,
   lsu_axi_if.master ax
);
   localparam int SW = DATA_W / 8;
   localparam int OW = $clog2(SW);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

   typedef struct packed {
      logic [1:0]    size;
      logic          sgn;
      logic [OW-1:0] off;
   } req_t;

   state_t            state;
   req_t              cur;
   logic [OW-1:0]     off;
   logic [3:0]        nb;
   logic              bad;
   logic [ADDR_W-1:0] aligned;
   logic              unused_resp;

   assign off         = up.addr_i[OW-1:0];
   assign aligned     = {up.addr_i[ADDR_W-1:OW], {OW{1'b0}}};
   assign unused_resp = ax.rresp_i[0] ^ ax.bresp_i[0];

   always_comb begin
      nb  = 4'd1 << up.size_i;
      bad = (up.wen_i && up.ren_i)
         || ((off & OW'(nb - 4'd1)) != '0)
         || (DATA_W == 32 && up.size_i == 2'd3);
   end

   // Right-justify the addressed lane, then a left/right shift pair trims it
   // to NB bytes and sign- or zero-extends in one step.
   function automatic logic [DATA_W-1:0] ld_ext(input logic [DATA_W-1:0] d, input req_t r);
      logic        [DATA_W-1:0] s;
      logic signed [DATA_W-1:0] ss;
      logic        [6:0]        sh;
      s  = d >> {r.off, 3'b000};
      sh = 7'(DATA_W) - (7'd8 << r.size);
      s  = s << sh;
      ss = $signed(s) >>> sh;
      return r.sgn ? $unsigned(ss) : (s >> sh);
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         cur             <= '0;
         up.req_ready_o  <= 1'b1;
         up.resp_valid_o <= 1'b0;
         up.rdata_o      <= '0;
         up.err_o        <= 1'b0;
         ax.awvalid_o    <= 1'b0;
         ax.awaddr_o     <= '0;
         ax.wvalid_o     <= 1'b0;
         ax.wdata_o      <= '0;
         ax.wstrb_o      <= '0;
         ax.bready_o     <= 1'b0;
         ax.arvalid_o    <= 1'b0;
         ax.araddr_o     <= '0;
         ax.rready_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (up.req_valid_i && up.req_ready_o) begin
               up.req_ready_o <= 1'b0;
               cur.size       <= up.size_i;
               cur.sgn        <= up.is_signed_i;
               cur.off        <= off;
               if (bad || !(up.wen_i || up.ren_i)) begin
                  up.resp_valid_o <= 1'b1;
                  up.err_o        <= bad;
                  up.rdata_o      <= '0;
                  state           <= RESP;
               end else if (up.ren_i) begin
                  ax.arvalid_o <= 1'b1;
                  ax.araddr_o  <= aligned;
                  state        <= RD_ADDR;
               end else begin
                  ax.awvalid_o <= 1'b1;
                  ax.awaddr_o  <= aligned;
                  ax.wvalid_o  <= 1'b1;
                  ax.wdata_o   <= up.wdata_i << {off, 3'b000};
                  ax.wstrb_o   <= SW'((16'd1 << nb) - 16'd1) << off;
                  state        <= WR;
               end
            end
            RD_ADDR: if (ax.arready_i) begin
               ax.arvalid_o <= 1'b0;
               ax.rready_o  <= 1'b1;
               state        <= RD_DATA;
            end
            RD_DATA: if (ax.rvalid_i) begin
               ax.rready_o     <= 1'b0;
               up.rdata_o      <= ld_ext(ax.rdata_i, cur);
               up.err_o        <= ax.rresp_i[1];
               up.resp_valid_o <= 1'b1;
               state           <= RESP;
            end
            WR: begin
               // AW and W retire independently; leave once neither is pending.
               if (ax.awready_i) ax.awvalid_o <= 1'b0;
               if (ax.wready_i)  ax.wvalid_o  <= 1'b0;
               if ((!ax.awvalid_o || ax.awready_i) && (!ax.wvalid_o || ax.wready_i)) begin
                  ax.bready_o <= 1'b1;
                  state       <= WR_RESP;
               end
            end
            WR_RESP: if (ax.bvalid_i) begin
               ax.bready_o     <= 1'b0;
               up.err_o        <= ax.bresp_i[1];
               up.rdata_o      <= '0;
               up.resp_valid_o <= 1'b1;
               state           <= RESP;
            end
            RESP: if (up.resp_ready_i) begin
               up.resp_valid_o <= 1'b0;
               up.req_ready_o  <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: a 32-bit instance driven by directed and random transactions
// against an arithmetic reference model, plus a 64-bit instance for wide loads.
module tb_lsu_axi;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_req_if #(.ADDR_W(32), .DATA_W(32)) u32 ();
   lsu_axi_if #(.ADDR_W(32), .DATA_W(32)) a32 ();
   lsu_req_if #(.ADDR_W(32), .DATA_W(64)) u64 ();
   lsu_axi_if #(.ADDR_W(32), .DATA_W(64)) a64 ();

   lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut32 (.clk_i(clk), .rst_i(rst), .up(u32), .ax(a32));
   lsu_axi #(.ADDR_W(32), .DATA_W(64)) dut64 (.clk_i(clk), .rst_i(rst), .up(u64), .ax(a64));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          wen, ren, sgn;
      logic [31:0] addr, wdata, sdata;
      logic [1:0]  size, sresp;
      int          aw_dly, w_dly, ar_dly, r_dly, b_dly, rr_dly;
   } txn_t;

   // Reference: expected outcome from the transaction rules using plain arithmetic.
   function automatic void model(input txn_t t, output bit xerr, output logic [31:0] xdata,
                                 output int kind, output int xlat, output logic [31:0] xaddr,
                                 output logic [31:0] xwdata, output logic [3:0] xstrb);
      longint unsigned nb, off, val;
      nb     = 64'd1 << t.size;
      off    = 64'(t.addr) % 64'd4;
      xaddr  = t.addr - 32'(off);
      xwdata = 32'((64'(t.wdata) * (64'd1 << (8 * off))) % 64'h1_0000_0000);
      xstrb  = 4'(((64'd1 << nb) - 64'd1) * (64'd1 << off));
      xdata  = '0;
      xerr   = 1'b0;
      if ((t.wen && t.ren) || (off % nb != 0) || t.size == 2'd3) begin
         kind = 0; xerr = 1'b1; xlat = 1;
      end else if (!t.wen && !t.ren) begin
         kind = 0; xlat = 1;
      end else if (t.ren) begin
         kind = 1;
         val  = (64'(t.sdata) / (64'd1 << (8 * off))) % (64'd1 << (8 * nb));
         if (t.sgn && val >= (64'd1 << (8 * nb - 1)))
            val = val + 64'h1_0000_0000 - (64'd1 << (8 * nb));
         xdata = 32'(val);
         xerr  = t.sresp >= 2'd2;
         xlat  = 3 + t.ar_dly + t.r_dly;
      end else begin
         kind = 2;
         xerr = t.sresp >= 2'd2;
         xlat = 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
      end
   endfunction

   task automatic clr32();
      u32.req_valid_i = 0; u32.resp_ready_i = 0;
      a32.arready_i = 0; a32.rvalid_i = 0; a32.awready_i = 0; a32.wready_i = 0; a32.bvalid_i = 0;
   endtask

   task automatic run32(input string tag, input txn_t t, output logic [31:0] got_d, output bit got_e);
      bit          xerr, r_pend, b_pend, done, proto, seen, anybus;
      logic [31:0] xdata, xaddr, xwdata, g_ar, g_aw, g_wd;
      logic [3:0]  xstrb, g_st;
      int          kind, xlat, lat, ar_w, r_w, aw_w, w_w, b_w, rr_w, ar_n, r_n, aw_n, w_n, b_n;
      model(t, xerr, xdata, kind, xlat, xaddr, xwdata, xstrb);
      {r_pend, b_pend, done, seen, anybus} = '0;
      proto = 1'b1;
      {lat, ar_w, r_w, aw_w, w_w, b_w, rr_w, ar_n, r_n, aw_n, w_n, b_n} = '0;
      {g_ar, g_aw, g_wd, g_st, got_d, got_e} = '0;
      @(negedge clk);
      chk({tag, ".req_ready"}, 64'(u32.req_ready_o), 64'd1);
      u32.req_valid_i = 1; u32.wen_i = t.wen; u32.ren_i = t.ren; u32.addr_i = t.addr;
      u32.wdata_i = t.wdata; u32.size_i = t.size; u32.is_signed_i = t.sgn;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         u32.req_valid_i = 0;
         if (u32.req_ready_o || (a32.arvalid_o && a32.awvalid_o)) proto = 0;
         if (a32.arvalid_o || a32.awvalid_o || a32.wvalid_o) anybus = 1;
         if (r_pend) begin
            a32.rvalid_i = (r_w >= t.r_dly); a32.rdata_i = t.sdata; a32.rresp_i = t.sresp; r_w++;
         end else a32.rvalid_i = 0;
         if (a32.rvalid_i && a32.rready_o) begin r_pend = 0; r_n++; end
         if (a32.arvalid_o) begin
            if (ar_w == 0) g_ar = a32.araddr_o; else if (a32.araddr_o !== g_ar) proto = 0;
            a32.arready_i = (ar_w >= t.ar_dly); ar_w++;
         end else a32.arready_i = 0;
         if (a32.arvalid_o && a32.arready_i) begin ar_n++; r_pend = 1; r_w = 0; end
         if (b_pend) begin
            a32.bvalid_i = (b_w >= t.b_dly); a32.bresp_i = t.sresp; b_w++;
         end else a32.bvalid_i = 0;
         if (a32.bvalid_i && a32.bready_o) begin b_pend = 0; b_n++; end
         if (a32.awvalid_o) begin
            if (aw_w == 0) g_aw = a32.awaddr_o; else if (a32.awaddr_o !== g_aw) proto = 0;
            a32.awready_i = (aw_w >= t.aw_dly); aw_w++;
         end else a32.awready_i = 0;
         if (a32.awvalid_o && a32.awready_i) aw_n++;
         if (a32.wvalid_o) begin
            if (w_w == 0) begin g_wd = a32.wdata_o; g_st = a32.wstrb_o; end
            else if (a32.wdata_o !== g_wd || a32.wstrb_o !== g_st) proto = 0;
            a32.wready_i = (w_w >= t.w_dly); w_w++;
         end else a32.wready_i = 0;
         if (a32.wvalid_o && a32.wready_i) w_n++;
         if (aw_n > 0 && w_n > 0 && b_n == 0 && !b_pend) begin b_pend = 1; b_w = 0; end
         if (u32.resp_valid_o) begin
            if (!seen) begin seen = 1; lat = c; got_d = u32.rdata_o; got_e = u32.err_o; end
            else if (u32.rdata_o !== got_d || u32.err_o !== got_e) proto = 0;
            u32.resp_ready_i = (rr_w >= t.rr_dly); rr_w++;
            if (u32.resp_ready_i) done = 1;
         end else begin
            u32.resp_ready_i = 0;
            if (seen) proto = 0;
         end
      end
      @(negedge clk);
      clr32();
      chk({tag, ".done"},     64'(done), 64'd1);
      chk({tag, ".idle_rdy"}, 64'(u32.req_ready_o), 64'd1);
      chk({tag, ".idle_rv"},  64'(u32.resp_valid_o), 64'd0);
      chk({tag, ".proto"},    64'(proto), 64'd1);
      chk({tag, ".lat"},      64'(lat), 64'(xlat));
      chk({tag, ".err"},      64'(got_e), 64'(xerr));
      chk({tag, ".rdata"},    64'(got_d), 64'(xdata));
      chk({tag, ".ar_n"},     64'(ar_n), (kind == 1) ? 64'd1 : 64'd0);
      chk({tag, ".r_n"},      64'(r_n),  (kind == 1) ? 64'd1 : 64'd0);
      chk({tag, ".aw_n"},     64'(aw_n), (kind == 2) ? 64'd1 : 64'd0);
      chk({tag, ".w_n"},      64'(w_n),  (kind == 2) ? 64'd1 : 64'd0);
      chk({tag, ".b_n"},      64'(b_n),  (kind == 2) ? 64'd1 : 64'd0);
      if (kind == 0) chk({tag, ".nobus"}, 64'(anybus), 64'd0);
      if (kind == 1) chk({tag, ".araddr"}, 64'(g_ar), 64'(xaddr));
      if (kind == 2) begin
         chk({tag, ".awaddr"}, 64'(g_aw), 64'(xaddr));
         chk({tag, ".wdata"},  64'(g_wd), 64'(xwdata));
         chk({tag, ".wstrb"},  64'(g_st), 64'(xstrb));
      end
   endtask

   task automatic load64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input bit sgn, input logic [63:0] sdata, input logic [63:0] exp);
      int n;
      @(negedge clk);
      u64.req_valid_i = 1; u64.ren_i = 1; u64.wen_i = 0; u64.addr_i = addr;
      u64.size_i = size; u64.is_signed_i = sgn; u64.wdata_i = '0;
      @(negedge clk);
      u64.req_valid_i = 0;
      n = 0;
      while (!a64.arvalid_o && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".araddr"}, 64'(a64.araddr_o), 64'(addr & ~32'h7));
      a64.arready_i = 1;
      @(negedge clk);
      a64.arready_i = 0; a64.rvalid_i = 1; a64.rdata_i = sdata; a64.rresp_i = 2'b00;
      while (!a64.rready_o && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      a64.rvalid_i = 0;
      while (!u64.resp_valid_o && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".in_time"}, 64'(n < 20), 64'd1);
      chk({tag, ".rdata"}, u64.rdata_o, exp);
      chk({tag, ".err"}, 64'(u64.err_o), 64'd0);
      u64.resp_ready_i = 1;
      @(negedge clk);
      u64.resp_ready_i = 0;
   endtask

   initial begin
      txn_t        t;
      logic [31:0] gd;
      bit          ge;
      clr32();
      {u32.wen_i, u32.ren_i, u32.is_signed_i, u32.addr_i, u32.wdata_i, u32.size_i} = '0;
      {a32.rdata_i, a32.rresp_i, a32.bresp_i} = '0;
      {u64.req_valid_i, u64.resp_ready_i, u64.wen_i, u64.ren_i, u64.is_signed_i} = '0;
      {u64.addr_i, u64.wdata_i, u64.size_i} = '0;
      {a64.arready_i, a64.rvalid_i, a64.awready_i, a64.wready_i, a64.bvalid_i} = '0;
      {a64.rdata_i, a64.rresp_i, a64.bresp_i} = '0;
      rst = 1;
      repeat (3) @(negedge clk);
      chk("rst.req_ready", 64'(u32.req_ready_o), 64'd1);
      chk("rst.valids", 64'({u32.resp_valid_o, a32.arvalid_o, a32.awvalid_o, a32.wvalid_o}), 64'd0);
      chk("rst.readies", 64'({a32.rready_o, a32.bready_o}), 64'd0);
      chk("rst.rdata_err", 64'({u32.err_o, u32.rdata_o}), 64'd0);
      rst = 0;

      t = '{default: 0};
      t.ren = 1; t.sgn = 1; t.addr = 32'h8000_0003; t.size = 2'd0; t.sdata = 32'h80FF_FF12;
      run32("ld_byte_s", t, gd, ge);
      chk("ld_byte_s.const", 64'(gd), 64'hFFFF_FF80);

      t = '{default: 0};
      t.wen = 1; t.addr = 32'h8000_0002; t.size = 2'd1; t.wdata = 32'h0000_BEEF; t.w_dly = 2;
      run32("st_half", t, gd, ge);
      chk("st_half.err", 64'(ge), 64'd0);

      t = '{default: 0};
      t.ren = 1; t.addr = 32'h8000_0001; t.size = 2'd2;
      run32("misalign", t, gd, ge);
      chk("misalign.err", 64'(ge), 64'd1);

      t = '{default: 0};
      t.ren = 1; t.addr = 32'h0000_0010; t.size = 2'd2; t.sdata = 32'h1234_5678;
      t.sresp = 2'b10; t.rr_dly = 3;
      run32("slverr", t, gd, ge);
      chk("slverr.err", 64'(ge), 64'd1);

      t = '{default: 0};
      t.addr = 32'h44;
      run32("noop", t, gd, ge);
      t.wen = 1; t.ren = 1; t.size = 2'd2;
      run32("rw_both", t, gd, ge);
      t.ren = 0; t.size = 2'd3; t.addr = 32'h40;
      run32("dword32", t, gd, ge);

      // Reset while waiting for read data.
      @(negedge clk);
      u32.req_valid_i = 1; u32.ren_i = 1; u32.wen_i = 0; u32.addr_i = 32'h100; u32.size_i = 2'd2;
      @(negedge clk);
      u32.req_valid_i = 0; a32.arready_i = 1;
      @(negedge clk);
      a32.arready_i = 0;
      chk("mid_rst.pre_rready", 64'(a32.rready_o), 64'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_rst.arvalid", 64'(a32.arvalid_o), 64'd0);
      chk("mid_rst.rready", 64'(a32.rready_o), 64'd0);
      chk("mid_rst.req_ready", 64'(u32.req_ready_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst.no_resp", 64'(u32.resp_valid_o), 64'd0);
         @(negedge clk);
      end

      for (int i = 0; i < 80; i++) begin
         int k;
         t = '{default: 0};
         k = int'($urandom_range(0, 10));
         t.ren = (k <= 4) || (k == 9);
         t.wen = (k >= 5 && k <= 9);
         t.size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         t.addr = $urandom;
         if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
         t.sgn = 1'($urandom);
         t.wdata = $urandom; t.sdata = $urandom;
         t.sresp = {($urandom_range(0, 3) == 0), 1'($urandom)};
         t.aw_dly = int'($urandom_range(0, 3)); t.w_dly = int'($urandom_range(0, 3));
         t.ar_dly = int'($urandom_range(0, 3)); t.r_dly = int'($urandom_range(0, 3));
         t.b_dly = int'($urandom_range(0, 3)); t.rr_dly = int'($urandom_range(0, 2));
         run32($sformatf("rnd%0d", i), t, gd, ge);
      end

      load64("w64_half_u", 32'h0000_1006, 2'd1, 1'b0, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD);
      load64("w64_byte_s", 32'h0000_2005, 2'd0, 1'b1, 64'h0000_9A00_0000_0000, 64'hFFFF_FFFF_FFFF_FF9A);
      load64("w64_word_s", 32'h0000_3004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
      load64("w64_dword",  32'h0000_4000, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
